move_input_queue: RTL and testbench

- Producer side of the game-loop move interface. Conditions the raw IO-shield direction buttons: synchronizes, debounces and edge-detects each one.
- Encodes each press into a 2-bit move and buffers moves in a small FIFO.
- Presents moves to the game loop over a valid/ready handshake, one move per accepted transfer.
- Sits between the io_button pins and the game loop in the top level.

---
 rtl/move_input_queue.sv | 171 +++++++++++++++++
 tb/tb_move_input_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_queue.sv
`default_nettype none
// ============================================================================
// Module      : move_input_queue
// Description : Producer side of the game-loop move interface. Each raw
//               direction button is synchronized, debounced and edge-detected.
//               Every press is encoded as a 2-bit move and queued in a small
//               FIFO. Moves are handed to the game loop over valid/ready,
//               one move per accepted transfer.
// Ports       : clk        - system clock (50 MHz)
//               rst_n      - synchronous active-low reset
//               btn_up     - raw button, asynchronous, active-high
//               btn_down   - raw button, asynchronous, active-high
//               btn_left   - raw button, asynchronous, active-high
//               btn_right  - raw button, asynchronous, active-high
//               move_valid - head of queue holds a move
//               move_dir   - head move: 0=up, 1=down, 2=left, 3=right
//               move_ready - game loop accepts the head this cycle
//               move_count - number of queued moves (0..FIFO_DEPTH)
//               overflow   - one-cycle pulse: a press was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module move_input_queue #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                btn_up,
    input  logic                                btn_down,
    input  logic                                btn_left,
    input  logic                                btn_right,
    output logic                                move_valid,
    output logic [1:0]                          move_dir,
    input  logic                                move_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     move_count,
    output logic                                overflow
);

    localparam int c_db_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_count_w  = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_db_cnt_w-1:0] c_db_last = c_db_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_count_w-1:0]  c_full    = c_count_w'(FIFO_DEPTH);

    // Bit index doubles as the move encoding and the priority order
    // (lowest index wins).
    logic [3:0] w_btn_raw;
    logic [3:0] w_press;

    assign w_btn_raw = {btn_right, btn_left, btn_down, btn_up};

    // ------------------------------------------------------------------------
    // Per-button conditioning: synchronizer -> debounce -> rising-edge detect
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_db_cnt_w-1:0]  r_cnt;
        logic                   r_db;
        logic                   r_db_q;
        logic                   w_sync_out;

        assign w_sync_out = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_db   <= 1'b0;
                r_db_q <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_btn_raw[g]};
                r_db_q <= r_db;
                // Counter runs only while the synchronized level disagrees
                // with the debounced state; any agreement restarts it.
                if (w_sync_out == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_db  <= w_sync_out;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_db_cnt_w'(1);
                end
            end
        end

        assign w_press[g] = r_db & ~r_db_q;
    end

    // ------------------------------------------------------------------------
    // Press encoding: highest-priority press wins, others are dropped
    // ------------------------------------------------------------------------
    logic       w_any;
    logic       w_multi;
    logic [1:0] w_dir;

    assign w_any   = |w_press;
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi = (w_press & (w_press - 4'd1)) != 4'd0;

    always_comb begin
        w_dir = 2'd0;
        if (w_press[0]) begin
            w_dir = 2'd0;
        end else if (w_press[1]) begin
            w_dir = 2'd1;
        end else if (w_press[2]) begin
            w_dir = 2'd2;
        end else if (w_press[3]) begin
            w_dir = 2'd3;
        end
    end

    // ------------------------------------------------------------------------
    // Move FIFO
    // ------------------------------------------------------------------------
    logic [1:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_count_w-1:0] r_count;
    logic                 r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_full    = (r_count == c_full);
    // Ready while empty is ignored, so a same-cycle push into an empty
    // queue never sees a pop.
    assign w_pop     = (r_count != '0) & move_ready;
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign w_push_ok = w_any & (~w_full | w_pop);
    assign w_drop    = w_any & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_dir;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + c_count_w'(1);
                2'b01:   r_count <= r_count - c_count_w'(1);
                default: r_count <= r_count;
            endcase
            r_overflow <= w_multi | w_drop;
        end
    end

    // Head is read straight from registered storage; move_ready only moves
    // the read pointer at the next edge.
    assign move_valid = (r_count != '0);
    assign move_dir   = r_mem[r_rd_ptr];
    assign move_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_move_input_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_input_queue
// Description : Self-checking bench for move_input_queue. A behavioural model
//               (raw-sample history window + move queue) predicts outputs and
//               is compared every cycle; directed sections pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_input_queue;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int FIFO_DEPTH      = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btns;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic [2:0] move_count;
    logic       overflow;

    move_input_queue #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up     (btns[0]),
        .btn_down   (btns[1]),
        .btn_left   (btns[2]),
        .btn_right  (btns[3]),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .move_ready (move_ready),
        .move_count (move_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Behavioural model. A button's debounced level flips once the last
    // DEBOUNCE_CYCLES synchronized observations all disagree with it; the
    // synchronized observation at an edge is the raw sample taken
    // SYNC_STAGES edges earlier (zero before reset release).
    // ------------------------------------------------------------------------
    bit hist [4][$];
    bit m_db   [4];
    bit m_db_q [4];
    int m_q    [$];
    bit m_ovf;

    always @(posedge clk) begin
        bit pr [4];
        int np;
        int first;
        bit pop;
        bit push;
        bit ovf;
        bit all_diff;
        bit v;
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                hist[b].delete();
                m_db[b]   = 1'b0;
                m_db_q[b] = 1'b0;
            end
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            np    = 0;
            first = -1;
            for (int b = 0; b < 4; b++) begin
                pr[b] = m_db[b] && !m_db_q[b];
                if (pr[b]) begin
                    np++;
                    if (first < 0) first = b;
                end
            end
            pop  = (m_q.size() != 0) && move_ready;
            push = 1'b0;
            ovf  = 1'b0;
            if (np > 0) begin
                if (np > 1) ovf = 1'b1;
                if (m_q.size() < FIFO_DEPTH || pop) push = 1'b1;
                else ovf = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(first);
            m_ovf = ovf;
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                for (int k = SYNC_STAGES - 1; k <= SYNC_STAGES + DEBOUNCE_CYCLES - 2; k++) begin
                    v = (k < hist[b].size()) ? hist[b][k] : 1'b0;
                    if (v == m_db[b]) all_diff = 1'b0;
                end
                m_db_q[b] = m_db[b];
                if (all_diff) m_db[b] = !m_db[b];
                hist[b].push_front(btns[b]);
                if (hist[b].size() > SYNC_STAGES + DEBOUNCE_CYCLES) void'(hist[b].pop_back());
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks;
    int errors;
    int ovf_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("model_valid", 32'(move_valid), 32'(m_q.size() != 0));
        chk("model_count", 32'(move_count), 32'(m_q.size()));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() != 0) chk("model_dir", 32'(move_dir), 32'(m_q[0]));
        if (overflow === 1'b1) ovf_cycles++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int b);
        btns[b] = 1'b1;
        wait_cyc(8);
        btns[b] = 1'b0;
        wait_cyc(8);
    endtask

    task automatic drain(input int n);
        move_ready = 1'b1;
        wait_cyc(n);
        move_ready = 1'b0;
    endtask

    initial begin
        int exp_seq [4];
        checks     = 0;
        errors     = 0;
        ovf_cycles = 0;
        rst_n      = 1'b0;
        btns       = 4'b0000;
        move_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                compare_model();
            end
        join_none

        // Reset state
        wait_cyc(3);
        chk("rst_valid", 32'(move_valid), 0);
        chk("rst_count", 32'(move_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_dir", 32'(move_dir), 0);
        rst_n = 1'b1;
        wait_cyc(1);

        // Latency: first sample at edge N, valid after edge N+6
        btns[0] = 1'b1;
        wait_cyc(6);
        chk("lat_early_valid", 32'(move_valid), 0);
        wait_cyc(1);
        chk("lat_valid", 32'(move_valid), 1);
        chk("lat_dir", 32'(move_dir), 0);
        chk("lat_count", 32'(move_count), 1);
        btns[0] = 1'b0;
        drain(1);
        chk("lat_pop_valid", 32'(move_valid), 0);
        chk("lat_pop_count", 32'(move_count), 0);
        wait_cyc(10);

        // Glitch rejection
        ovf_cycles = 0;
        btns[3] = 1'b1;
        wait_cyc(3);
        btns[3] = 1'b0;
        wait_cyc(12);
        chk("glitch_valid", 32'(move_valid), 0);
        chk("glitch_ovf", 32'(ovf_cycles), 0);
        btns[3] = 1'b1;
        wait_cyc(10);
        chk("hold_count", 32'(move_count), 1);
        chk("hold_dir", 32'(move_dir), 3);
        btns[3] = 1'b0;
        wait_cyc(15);
        chk("release_count", 32'(move_count), 1);
        drain(1);

        // Ordering and backpressure
        press_btn(2);
        press_btn(1);
        press_btn(3);
        chk("order_count", 32'(move_count), 3);
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            chk("stall_dir", 32'(move_dir), 2);
        end
        exp_seq = '{2, 1, 3, 0};
        move_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("order_seq", 32'(move_dir), 32'(exp_seq[i]));
            wait_cyc(1);
        end
        move_ready = 1'b0;
        chk("order_empty", 32'(move_valid), 0);

        // Full / overflow
        ovf_cycles = 0;
        press_btn(0);
        press_btn(1);
        press_btn(2);
        press_btn(3);
        press_btn(0);
        chk("full_count", 32'(move_count), 4);
        chk("full_ovf_pulses", 32'(ovf_cycles), 1);
        exp_seq = '{0, 1, 2, 3};
        move_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_seq", 32'(move_dir), 32'(exp_seq[i]));
            wait_cyc(1);
        end
        move_ready = 1'b0;
        chk("full_empty", 32'(move_valid), 0);

        // Push into full queue with simultaneous pop
        press_btn(3);
        press_btn(2);
        press_btn(1);
        press_btn(0);
        ovf_cycles = 0;
        btns[1] = 1'b1;
        wait_cyc(6);
        move_ready = 1'b1;
        wait_cyc(1);
        move_ready = 1'b0;
        chk("fullpop_count", 32'(move_count), 4);
        chk("fullpop_head", 32'(move_dir), 2);
        btns[1] = 1'b0;
        wait_cyc(10);
        chk("fullpop_ovf", 32'(ovf_cycles), 0);
        drain(4);

        // Simultaneous up + left
        ovf_cycles = 0;
        btns = 4'b0101;
        wait_cyc(8);
        btns = 4'b0000;
        wait_cyc(8);
        chk("simul_count", 32'(move_count), 1);
        chk("simul_dir", 32'(move_dir), 0);
        chk("simul_ovf", 32'(ovf_cycles), 1);
        drain(1);

        // Reset mid-operation, button held through reset
        press_btn(0);
        press_btn(1);
        press_btn(2);
        chk("mid_count", 32'(move_count), 3);
        btns[0] = 1'b1;
        wait_cyc(2);
        rst_n = 1'b0;
        wait_cyc(1);
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(move_valid), 0);
        chk("mid_rst_count", 32'(move_count), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        wait_cyc(8);
        chk("held_count", 32'(move_count), 1);
        chk("held_dir", 32'(move_dir), 0);
        btns[0] = 1'b0;
        wait_cyc(10);
        drain(1);

        // Randomized phase
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) btns[b] = ~btns[b];
            end
            move_ready = ($urandom_range(0, 2) == 0);
            rst_n      = ($urandom_range(0, 499) != 0);
            wait_cyc(1);
        end
        rst_n      = 1'b1;
        btns       = 4'b0000;
        move_ready = 1'b1;
        wait_cyc(20);
        chk("final_empty", 32'(move_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
